// File: rtl/seq_alu_if.sv
// seq_alu_if: issue/result bus between the execute stage and seq_alu.
interface seq_alu_if #(parameter int WIDTH = 64);
  logic start;
  logic [3:0] alu_control;
  logic [WIDTH-1:0] a, b, result;
  logic [3:0] flags;
  logic busy, done, illegal;
  modport master (output start, alu_control, a, b, input result, flags, busy, done, illegal);
  modport slave (input start, alu_control, a, b, output result, flags, busy, done, illegal);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with NZCV flags and iterative MUL (and SDIV/UDIV when ALU_DIVIDE_EN is defined).
module seq_alu #(
  parameter int WIDTH = 64,
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input logic clk,
  input logic reset,
  seq_alu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] acc, x, y, bx, sc_res, fin;
  logic [WIDTH:0] sum;
  logic [3:0] op;
  logic issue, is_mc, is_add, is_sub, sc_ok, sc_c, sc_v, fin_v;
  assign op = bus.alu_control;
  assign issue = bus.start && state == IDLE;
  assign is_add = op == 4'b0010;
  assign is_sub = op == 4'b0110;
  assign bx = is_sub ? ~bus.b : bus.b;
  assign sum = {1'b0, bus.a} + {1'b0, bx} + (WIDTH+1)'(is_sub);
  assign sc_ok = op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011};
  assign sc_res = op == 4'b0000 ? bus.a & bus.b :
                  op == 4'b0001 ? bus.a | bus.b :
                  op == 4'b0011 ? bus.a ^ bus.b :
                  op == 4'b0111 ? bus.b :
                  op == 4'b1100 ? ~(bus.a | bus.b) :
                  (is_add || is_sub) ? sum[WIDTH-1:0] : '0;
  assign sc_c = (is_add || is_sub) && sum[WIDTH];
  // with b already inverted for SUB, one overflow rule covers both
  assign sc_v = (is_add || is_sub) && bus.a[WIDTH-1] == bx[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1];
`ifdef ALU_DIVIDE_EN
  logic dv, neg, ovf, dz, sdiv, ge;
  logic [WIDTH:0] r_sh, r_sub;
  assign sdiv = op == 4'b1001;
  assign is_mc = op == 4'b1000 || sdiv || op == 4'b1010;
  assign r_sh = {acc, x[WIDTH-1]};
  assign r_sub = r_sh - {1'b0, y};
  assign ge = !r_sub[WIDTH];
  assign fin = !dv ? acc : dz ? '0 : neg ? -x : x;
  assign fin_v = ovf;
`else
  assign is_mc = op == 4'b1000;
  assign fin = acc;
  assign fin_v = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = issue && is_mc ? ITER : IDLE;
      ITER: state_n = count == CW'(WIDTH-1) ? FIX : ITER;
      default: state_n = IDLE;
    endcase
  end
  always_comb bus.busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.result <= '0;
      bus.flags <= FLAGS_RESET;
      bus.done <= 1'b0;
      bus.illegal <= 1'b0;
      count <= '0;
      acc <= '0;
      x <= '0;
      y <= '0;
`ifdef ALU_DIVIDE_EN
      dv <= 1'b0;
      neg <= 1'b0;
      ovf <= 1'b0;
      dz <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      bus.illegal <= 1'b0;
      case (state)
        IDLE: if (issue) begin
          if (is_mc) begin
            count <= '0;
            acc <= '0;
            x <= bus.a;
            y <= bus.b;
`ifdef ALU_DIVIDE_EN
            dv <= op != 4'b1000;
            neg <= sdiv && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            ovf <= sdiv && bus.a == {1'b1, {(WIDTH-1){1'b0}}} && &bus.b;
            dz <= bus.b == '0;
            if (sdiv) begin
              x <= bus.a[WIDTH-1] ? -bus.a : bus.a;
              y <= bus.b[WIDTH-1] ? -bus.b : bus.b;
            end
`endif
          end else begin
            bus.done <= 1'b1;
            bus.illegal <= !sc_ok;
            bus.result <= sc_res;
            if (sc_ok) bus.flags <= {sc_res[WIDTH-1], sc_res == '0, sc_c, sc_v};
          end
        end
        ITER: begin
          count <= count + CW'(1);
`ifdef ALU_DIVIDE_EN
          if (dv) begin
            acc <= ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
            x <= {x[WIDTH-2:0], ge};
          end else
`endif
          begin
            acc <= acc + (y[0] ? x : '0);
            x <= x << 1;
            y <= y >> 1;
          end
        end
        default: begin
          bus.result <= fin;
          bus.flags <= {fin[WIDTH-1], fin == '0, 1'b0, fin_v};
          bus.done <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;
  localparam int W = 8;
  localparam logic [3:0] FR = 4'b1010;
  logic clk = 0, reset = 1;
  int checks = 0, fails = 0;
  seq_alu_if #(.WIDTH(W)) bus();
  seq_alu #(.WIDTH(W), .FLAGS_RESET(FR)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    bus.start = 1; bus.alu_control = op; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 0;
  endtask

  task automatic run_mc(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y, output int n);
    issue(op, x, y);
    n = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin n = c; break; end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.result, bus.flags, bus.busy, bus.done, bus.illegal} !== {8'h00, FR, 3'b000}) begin
      fails++;
      $display("FAIL reset got res=%h fl=%b b/d/i=%b%b%b want res=00 fl=%b b/d/i=000", bus.result, bus.flags, bus.busy, bus.done, bus.illegal, FR);
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_single;
    logic [3:0] ops [8] = '{4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0011};
    logic [7:0] av [8] = '{8'h7F, 8'h05, 8'h00, 8'hCC, 8'hCC, 8'hCC, 8'h55, 8'h3C};
    logic [7:0] bv [8] = '{8'h01, 8'h05, 8'h01, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h0F};
    logic [7:0] er [8] = '{8'h80, 8'h00, 8'hFF, 8'h88, 8'hEE, 8'h11, 8'h00, 8'h33};
    logic [3:0] ef [8] = '{4'b1001, 4'b0110, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], av[i], bv[i]);
      checks++;
      if ({bus.done, bus.illegal, bus.busy, bus.result, bus.flags} !== {3'b100, er[i], ef[i]}) begin
        fails++;
        $display("FAIL single[%0d] got d/i/b=%b%b%b res=%h fl=%b want d/i/b=100 res=%h fl=%b", i, bus.done, bus.illegal, bus.busy, bus.result, bus.flags, er[i], ef[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL single_pulse done got %b want 0", bus.done); end
  endtask

  task automatic test_mul;
    issue(4'b1000, 8'hFD, 8'h07);
    checks++;
    if ({bus.busy, bus.done} !== 2'b10) begin fails++; $display("FAIL mul_start busy/done got %b%b want 10", bus.busy, bus.done); end
    for (int c = 1; c <= W + 1; c++) begin
      if (c == 4) begin bus.start = 1; bus.alu_control = 4'b0010; bus.a = 8'h01; bus.b = 8'h01; end
      @(posedge clk); #1;
      bus.start = 0;
      checks++;
      if ({bus.busy, bus.done} !== (c <= W ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL mul_cycle[%0d] busy/done got %b%b want %b", c, bus.busy, bus.done, (c <= W ? 2'b10 : 2'b01));
      end
      if (c == 5) begin
        checks++;
        if (bus.result !== 8'h33) begin fails++; $display("FAIL mul_hold result got %h want 33", bus.result); end
      end
    end
    checks++;
    if ({bus.result, bus.flags, bus.illegal} !== {8'hEB, 4'b1000, 1'b0}) begin
      fails++;
      $display("FAIL mul_result got res=%h fl=%b ill=%b want res=eb fl=1000 ill=0", bus.result, bus.flags, bus.illegal);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.result} !== {2'b00, 8'hEB}) begin
      fails++;
      $display("FAIL mul_noqueue got b/d=%b%b res=%h want b/d=00 res=eb", bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    issue(4'b1000, 8'h0F, 8'h0F);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.flags} !== {2'b00, 8'h00, FR}) begin
      fails++;
      $display("FAIL reset_mid got b/d=%b%b res=%h fl=%b want b/d=00 res=00 fl=%b", bus.busy, bus.done, bus.result, bus.flags, FR);
    end
    @(posedge clk); #1;
    reset = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL reset_discard active cycles got %0d want 0", seen); end
    issue(4'b0011, 8'hF0, 8'hFF);
    checks++;
    if ({bus.done, bus.result, bus.flags} !== {1'b1, 8'h0F, 4'b0000}) begin
      fails++;
      $display("FAIL reset_xor got d=%b res=%h fl=%b want d=1 res=0f fl=0000", bus.done, bus.result, bus.flags);
    end
  endtask

  task automatic test_illegal;
    logic [3:0] bad [3] = '{4'b1111, 4'b1001, 4'b1010};
    int nb;
`ifdef ALU_DIVIDE_EN
    nb = 1;
`else
    nb = 3;
`endif
    issue(4'b0110, 8'h00, 8'h01);
    for (int i = 0; i < nb; i++) begin
      issue(bad[i], 8'h12, 8'h34);
      checks++;
      if ({bus.done, bus.illegal, bus.busy, bus.result, bus.flags} !== {3'b110, 8'h00, 4'b1000}) begin
        fails++;
        $display("FAIL illegal[%b] got d/i/b=%b%b%b res=%h fl=%b want d/i/b=110 res=00 fl=1000", bad[i], bus.done, bus.illegal, bus.busy, bus.result, bus.flags);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.done, bus.illegal, bus.busy} !== 3'b000) begin fails++; $display("FAIL illegal_pulse d/i/b got %b%b%b want 000", bus.done, bus.illegal, bus.busy); end
  endtask

  task automatic test_divide;
`ifdef ALU_DIVIDE_EN
    logic [3:0] ops [3] = '{4'b1001, 4'b1010, 4'b1001};
    logic [7:0] av [3] = '{8'h80, 8'h07, 8'hF9};
    logic [7:0] bv [3] = '{8'hFF, 8'h00, 8'h02};
    logic [7:0] er [3] = '{8'h80, 8'h00, 8'hFD};
    logic [3:0] ef [3] = '{4'b1001, 4'b0100, 4'b1000};
    int n;
    for (int i = 0; i < 3; i++) begin
      run_mc(ops[i], av[i], bv[i], n);
      checks++;
      if (n !== W + 1 || {bus.result, bus.flags, bus.illegal} !== {er[i], ef[i], 1'b0}) begin
        fails++;
        $display("FAIL div[%0d] got lat=%0d res=%h fl=%b ill=%b want lat=%0d res=%h fl=%b ill=0", i, n, bus.result, bus.flags, bus.illegal, W + 1, er[i], ef[i]);
      end
    end
`endif
  endtask

  task automatic test_back_to_back;
    int n;
    run_mc(4'b1000, 8'h10, 8'h10, n);
    checks++;
    if (n !== W + 1 || {bus.result, bus.flags} !== {8'h00, 4'b0100}) begin
      fails++;
      $display("FAIL b2b_mul got lat=%0d res=%h fl=%b want lat=%0d res=00 fl=0100", n, bus.result, bus.flags, W + 1);
    end
    issue(4'b0010, 8'h80, 8'h80);
    checks++;
    if ({bus.done, bus.busy, bus.result, bus.flags} !== {2'b10, 8'h00, 4'b0111}) begin
      fails++;
      $display("FAIL b2b_add got d/b=%b%b res=%h fl=%b want d/b=10 res=00 fl=0111", bus.done, bus.busy, bus.result, bus.flags);
    end
  endtask

  initial begin
    bus.start = 0; bus.alu_control = 0; bus.a = 0; bus.b = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_mul;
    test_reset_mid;
    test_illegal;
    test_divide;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
